// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry ring buffer with
// valid/ready handshakes on both sides, flush on redirect and a sticky overflow flag.
module ir_queue #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4,
    parameter int OPW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ins_valid,
    input  logic [DWIDTH-1:0]        ins,
    output logic                     ins_ready,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [DWIDTH-1:0]        ir_out,
    output logic [OPW-1:0]           ir_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ir_queue: DEPTH must be a power of two and at least 2");
    end
    if (OPW < 1 || OPW > DWIDTH) begin : g_bad_opw
        $error("ir_queue: OPW must lie in 1..DWIDTH");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf_q;
    logic              push;
    logic              pop;

    // Handshake readiness comes only from registered occupancy, so there is
    // no combinational path from ir_ready back to ins_ready.
    assign ins_ready = (cnt != FULL);
    assign ir_valid  = (cnt != '0);
    assign push      = ins_valid && ins_ready && !flush;
    assign pop       = ir_valid && ir_ready && !flush;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky: flush leaves it alone, only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ins_valid && !ins_ready && !flush) begin
            ovf_q <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy gates every
    // read, so stale words are never observable and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= ins;
        end
    end

    assign ir_out = ir_valid ? mem[rd_ptr] : '0;
    assign ir_op  = ir_out[DWIDTH-1 -: OPW];
    assign count  = cnt;
    assign ovf    = ovf_q;

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction queue that replaces the single-entry instruction register between instruction fetch and decode. It buffers up to DEPTH fetched instruction words in arrival order. Words enter and leave through valid/ready handshakes, and the queue presents the head word together with its pre-extracted opcode field. A flush discards all buffered words on a branch or redirect, and a sticky flag records any push the queue refused.

## Interface
- DWIDTH, 16: instruction word width in bits.
- DEPTH, 4: number of queue entries; must be a power of two and at least 2.
- OPW, 4: opcode field width, taken from the top bits of the word; 1 ≤ OPW ≤ DWIDTH.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discards all queue contents at the next edge.
- ins_valid  in  1  fetch presents a word on ins.
- ins  in  DWIDTH  instruction word from fetch.
- ins_ready  out  1  queue can accept a word this cycle.
- ir_valid  out  1  the head word is valid.
- ir_ready  in  1  decode accepts the head word this cycle.
- ir_out  out  DWIDTH  head instruction word.
- ir_op  out  OPW  equals ir_out[DWIDTH-1 -: OPW].
- count  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- ovf  out  1  sticky flag: a word was offered while the queue was full.

## Operation
- Storage is a ring of DEPTH registers, with rd_ptr and wr_ptr each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH naturally.
- A push happens when ins_valid && ins_ready && !flush: mem[wr_ptr] <= ins, wr_ptr += 1.
- A pop happens when ir_valid && ir_ready && !flush: rd_ptr += 1.
- count updates as +1 on push only, −1 on pop only, and is unchanged when both or neither occur.
- ins_ready = (count != DEPTH). It depends only on registered state and has no combinational path from ir_ready.
- ir_valid = (count != 0).
- ir_out = mem[rd_ptr] when ir_valid, otherwise all zeros. ir_op follows ir_out, so it is zero when the queue is empty.
- Flush: rd_ptr, wr_ptr and count all go to 0 at the next edge.
  - A push or pop in the same cycle is ignored.
  - mem contents are don't-care after a flush.
  - ovf is not affected.
- ovf is set at the edge of any cycle where ins_valid && !ins_ready && !flush. Only rst clears it.
- Priority order: rst > flush > push/pop.

## Timing
- Reset values at the first edge with rst=1:
  - count=0, rd_ptr=0, wr_ptr=0.
  - ir_valid=0, ir_out=0, ir_op=0.
  - ins_ready=1, ovf=0.
  - mem contents are don't-care.
- rst asserted mid-stream behaves like a flush that also clears ovf. Handshake inputs in that cycle are ignored.
- Latency: a word pushed at edge N is visible on ir_out with ir_valid=1 right after edge N. There is no same-cycle bypass from ins to ir_out.
- Throughput is one push and one pop per cycle, sustained at any count from 1 to DEPTH−1.
- Empty (count=0):
  - A pop is impossible.
  - A push gives count=1 after the edge.
- Full (count=DEPTH):
  - ins_ready=0 even when ir_ready=1, so no push is accepted.
  - A pop gives count=DEPTH−1, and ins_ready=1 in the following cycle.
- Holding: when ir_ready=0 and ir_valid=1, ir_out and ir_op stay stable until the pop.
- Fetch must hold ins stable while ins_valid=1 && ins_ready=0. The queue does not check this.

## Test plan
- Reset: drive rst=1 for 2 cycles with ins_valid=1 and ins=0xFFFF -> count=0, ir_valid=0, ir_out=0x0000, ins_ready=1, ovf=0.
- Fill and drain (DEPTH=4, OPW=4):
  - Push 0x1001, 0x2002, 0x3003, 0x4004 on consecutive cycles with ir_ready=0 -> count=4, ins_ready=0, ir_out=0x1001, ir_op=0x1.
  - Then hold ir_ready=1 -> ir_out shows 0x1001, 0x2002, 0x3003, 0x4004 on successive cycles, followed by ir_valid=0.
- Simultaneous push/pop:
  - At count=2, push and pop together for 5 cycles -> count stays 2 and output order is preserved.
  - At count=4, offer a push with ir_ready=1 -> the push is refused, count=3, and ins_ready=1 in the next cycle.
- Flush:
  - At count=3, assert flush with ins_valid=1 and ins=0xABCD -> count=0 and ir_valid=0 next cycle; 0xABCD is never output.
  - The next push of 0x5005 then appears at ir_out.
- Overflow: fill to 4, hold ins_valid=1 for 1 cycle, then flush -> ovf=1 and stays 1 after the flush; only rst clears it.
- Wrap-around: push 10 words 0x0001..0x000A interleaved with pops, keeping count ≤3 -> every word is output exactly once, in order, across pointer wrap; count=0 at the end.
